// File: rtl/ff256_mult_arbiter_pkg.sv
// Shared constants for the GF(256) multiplier arbiter: sequencer encodings,
// the zero byte and the field doubling step for polynomial 0x11B.
package ff256_mult_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_MULT = 2'd1;
   localparam logic [1:0] ARB_DONE = 2'd2;

   localparam logic [7:0] FF256_ZERO = 8'h00;

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf256_xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

endpackage

// File: rtl/ff256_mult_multiplier.sv
// Combinational GF(256) multiplier, field polynomial 0x11B.
module ff256_mult_multiplier
   import ff256_mult_arbiter_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p_out
);

   logic [7:0] acc;
   logic [7:0] shifted;

   // Shift-and-add: accumulate a * x^i for every set bit i of b.
   always_comb begin
      acc     = FF256_ZERO;
      shifted = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ shifted;
         shifted = gf256_xtime(shifted);
      end
      p_out = acc;
   end

endmodule

// File: rtl/ff256_rr_pick.sv
// Combinational round-robin select: first set request after last_id, wrapping.
module ff256_rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_id,
   output logic                found,
   output logic [ID_WIDTH-1:0] winner
);

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = int'(last_id) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) begin
            found  = 1'b1;
            winner = idx[ID_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/ff256_mult_arbiter.sv
// Shares one GF(256) multiplier among NUM_REQ clients with round-robin grant,
// a three-state IDLE/MULT/DONE sequencer and a broadcast result with one-hot ack.
module ff256_mult_arbiter
   import ff256_mult_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ID_WIDTH  = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [NUM_REQ*8-1:0]   a_i,
   input  logic [NUM_REQ*8-1:0]   b_i,
   output logic [NUM_REQ-1:0]     ack_o,
   output logic [7:0]             res_o,
   output logic [ID_WIDTH-1:0]    res_id_o,
   output logic                   busy_o,
   output logic [CNT_WIDTH-1:0]   op_cnt_o
);

   logic [1:0]          state_reg;
   logic [7:0]          op_a_reg;
   logic [7:0]          op_b_reg;
   logic [ID_WIDTH-1:0] cur_id_reg;
   logic [ID_WIDTH-1:0] last_id_reg;

   logic                found;
   logic [ID_WIDTH-1:0] winner;
   logic [7:0]          p_out;
   logic [7:0]          a_slice [NUM_REQ];
   logic [7:0]          b_slice [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign a_slice[gi] = a_i[gi*8 +: 8];
         assign b_slice[gi] = b_i[gi*8 +: 8];
      end
   endgenerate

   ff256_rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .req     (req_i),
      .last_id (last_id_reg),
      .found   (found),
      .winner  (winner)
   );

   ff256_mult_multiplier u_mult (
      .a     (op_a_reg),
      .b     (op_b_reg),
      .p_out (p_out)
   );

   assign busy_o = (state_reg == ARB_MULT) || (state_reg == ARB_DONE);

   // Result, ack, count and pointer all update on the MULT->DONE edge so that
   // everything a client observes is aligned to the single DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ARB_IDLE;
         op_a_reg    <= FF256_ZERO;
         op_b_reg    <= FF256_ZERO;
         cur_id_reg  <= '0;
         last_id_reg <= ID_WIDTH'(NUM_REQ - 1);
         ack_o       <= '0;
         res_o       <= FF256_ZERO;
         res_id_o    <= '0;
         op_cnt_o    <= '0;
      end else begin
         ack_o <= '0;
         case (state_reg)
            ARB_IDLE: begin
               if (found) begin
                  op_a_reg   <= a_slice[winner];
                  op_b_reg   <= b_slice[winner];
                  cur_id_reg <= winner;
                  state_reg  <= ARB_MULT;
               end
            end
            ARB_MULT: begin
               res_o       <= p_out;
               res_id_o    <= cur_id_reg;
               ack_o       <= NUM_REQ'(1) << cur_id_reg;
               op_cnt_o    <= op_cnt_o + 1'b1;
               last_id_reg <= cur_id_reg;
               state_reg   <= ARB_DONE;
            end
            ARB_DONE: begin
               state_reg <= ARB_IDLE;
            end
            default: begin
               state_reg <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ff256_mult_arbiter.sv
// Directed bench for ff256_mult_arbiter: hand-computed GF(256) products,
// grant order, operand capture, reset abort and request withdrawal.
module tb_ff256_mult_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [3:0]  ack_o;
   logic [7:0]  res_o;
   logic [1:0]  res_id_o;
   logic        busy_o;
   logic [15:0] op_cnt_o;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ff256_mult_arbiter #(
      .NUM_REQ   (4),
      .ID_WIDTH  (2),
      .CNT_WIDTH (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .ack_o    (ack_o),
      .res_o    (res_o),
      .res_id_o (res_id_o),
      .busy_o   (busy_o),
      .op_cnt_o (op_cnt_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_i = '0;
      a_i   = '0;
      b_i   = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ack", 32'(ack_o), 32'h0);
      chk("rst_res", 32'(res_o), 32'h00);
      chk("rst_id", 32'(res_id_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_cnt", 32'(op_cnt_o), 32'h0);

      // Single request: 0x57 * 0x13 = 0xFE
      req_i = 4'b0001; a_i[7:0] = 8'h57; b_i[7:0] = 8'h13;
      tick();
      chk("single_busy_mult", 32'(busy_o), 32'h1);
      chk("single_noack_mult", 32'(ack_o), 32'h0);
      tick();
      chk("single_ack", 32'(ack_o), 32'h1);
      chk("single_res", 32'(res_o), 32'hFE);
      chk("single_id", 32'(res_id_o), 32'h0);
      chk("single_cnt", 32'(op_cnt_o), 32'h1);
      chk("single_busy_done", 32'(busy_o), 32'h1);
      req_i = 4'b0000;
      tick();
      chk("single_ack_clear", 32'(ack_o), 32'h0);
      chk("single_idle", 32'(busy_o), 32'h0);
      chk("single_res_hold", 32'(res_o), 32'hFE);

      // All four requesting after reset: order 0,1,2,3,0, each result = own a
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_i = 32'h04030201; b_i = 32'h01010101; req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         tick();
         chk($sformatf("rr%0d_ack", i), 32'(ack_o), 32'h1 << (i % 4));
         chk($sformatf("rr%0d_id", i), 32'(res_id_o), 32'(i % 4));
         chk($sformatf("rr%0d_res", i), 32'(res_o), 32'(1 + (i % 4)));
         tick();
      end
      req_i = 4'b0000;
      chk("rr_cnt", 32'(op_cnt_o), 32'd5);

      // Zero operand on requester 2
      a_i[23:16] = 8'h00; b_i[23:16] = 8'hFF; req_i = 4'b0100;
      tick();
      tick();
      chk("zero_ack", 32'(ack_o), 32'h4);
      chk("zero_res", 32'(res_o), 32'h00);
      req_i = 4'b0000;
      tick();

      // Operand change after grant: result still 0x57 * 0x83 = 0xC1
      a_i[15:8] = 8'h57; b_i[15:8] = 8'h83; req_i = 4'b0010;
      tick();
      a_i[15:8] = 8'h00;
      tick();
      chk("late_ack", 32'(ack_o), 32'h2);
      chk("late_res", 32'(res_o), 32'hC1);
      chk("late_cnt", 32'(op_cnt_o), 32'd7);
      req_i = 4'b0000;
      tick();

      // Reset in the MULT cycle aborts the operation
      a_i[31:24] = 8'h02; b_i[31:24] = 8'h03; req_i = 4'b1000;
      tick();
      reset = 1'b1; req_i = 4'b0000;
      tick();
      reset = 1'b0;
      chk("abort_ack", 32'(ack_o), 32'h0);
      chk("abort_res", 32'(res_o), 32'h00);
      chk("abort_id", 32'(res_id_o), 32'h0);
      chk("abort_busy", 32'(busy_o), 32'h0);
      chk("abort_cnt", 32'(op_cnt_o), 32'h0);
      tick();
      chk("abort_no_late_ack", 32'(ack_o), 32'h0);
      req_i = 4'b1000;
      tick();
      tick();
      chk("post_abort_ack", 32'(ack_o), 32'h8);
      chk("post_abort_res", 32'(res_o), 32'h06);
      chk("post_abort_id", 32'(res_id_o), 32'h3);
      chk("post_abort_cnt", 32'(op_cnt_o), 32'h1);
      req_i = 4'b0000;
      tick();

      // Withdraw: requester 0 pulses while requester 1 is being served
      a_i[15:8] = 8'h03; b_i[15:8] = 8'h03; req_i = 4'b0010;
      tick();
      req_i = 4'b0011;
      tick();
      chk("wd_ack1", 32'(ack_o), 32'h2);
      chk("wd_res", 32'(res_o), 32'h05);
      req_i = 4'b0000;
      tick();
      tick();
      chk("wd_no_ack_a", 32'(ack_o), 32'h0);
      tick();
      chk("wd_no_ack_b", 32'(ack_o), 32'h0);
      chk("wd_idle", 32'(busy_o), 32'h0);
      chk("wd_cnt", 32'(op_cnt_o), 32'h2);

      // Pointer at 1: requester 2 beats requester 0; 0x80*0x02 reduces to 0x1B
      a_i = 32'h00800010; b_i = 32'h00020002; req_i = 4'b0101;
      tick();
      tick();
      chk("ptr_ack2", 32'(ack_o), 32'h4);
      chk("ptr_res2", 32'(res_o), 32'h1B);
      req_i = 4'b0001;
      tick();
      tick();
      tick();
      chk("ptr_ack0", 32'(ack_o), 32'h1);
      chk("ptr_res0", 32'(res_o), 32'h20);
      chk("ptr_cnt", 32'(op_cnt_o), 32'h4);
      req_i = 4'b0000;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
